axi_ch_retime_skid: RTL

Parametrised AXI channel register slice: a chain of P_STAGES full-throughput skid-buffer stages.
- Every stage registers both data/valid forward and ready backward, so there is no combinational path o_rdy -> i_rdy and no i_data -> o_data path.
- Sustains one beat per cycle.
- Inserted on long AXI4/AXI4-Lite channel routes (AW/W/B/AR/R) where both timing closure and bandwidth matter.

---
 rtl/axi_ch_retime_skid.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/axi_ch_retime_skid.sv
// AXI channel register slice: P_STAGES chained full-throughput skid stages.
// Define AXI_CH_RETIME_SKID_OCC_EN to add the o_occ held-beat counter.
module axi_ch_retime_skid #(
  parameter int P_WIDTH  = 77,
  parameter int P_STAGES = 1,
  localparam int LP_OCC_W = (P_STAGES == 0) ? 1 : $clog2(2*P_STAGES+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic               i_val,
  output logic               i_rdy,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_val,
  input  logic               o_rdy
`ifdef AXI_CH_RETIME_SKID_OCC_EN
  ,
  output logic [LP_OCC_W-1:0] o_occ
`endif
);

  // state | meaning
  // EMPTY | main_v=0 skid_v=0, no beat held
  // BUSY  | main_v=1 skid_v=0, one beat on the stage output
  // FULL  | main_v=1 skid_v=1, output beat plus one parked in skid; i_rdy low
  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

  if (P_STAGES == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk ^ reset;
    assign o_data   = i_data;
    assign o_val    = i_val;
    assign i_rdy    = o_rdy;
`ifdef AXI_CH_RETIME_SKID_OCC_EN
    assign o_occ    = '0;
`endif
  end else begin : g_pipe
    logic [P_WIDTH-1:0] w_data [0:P_STAGES];
    logic [P_STAGES:0]  w_val;
    logic [P_STAGES:0]  w_rdy;
`ifdef AXI_CH_RETIME_SKID_OCC_EN
    logic [1:0]          w_cnt_nxt [0:P_STAGES-1];
    logic [LP_OCC_W-1:0] r_occ;
    logic [LP_OCC_W-1:0] w_occ_nxt;
`endif

    assign w_data[0]        = i_data;
    assign w_val[0]         = i_val;
    assign i_rdy            = w_rdy[0];
    assign o_data           = w_data[P_STAGES];
    assign o_val            = w_val[P_STAGES];
    assign w_rdy[P_STAGES]  = o_rdy;

    for (genvar k = 0; k < P_STAGES; k++) begin : g_stage
      state_t             r_state;
      state_t             w_state_nxt;
      logic [P_WIDTH-1:0] r_main;
      logic [P_WIDTH-1:0] r_skid;
      logic               r_rdy;
      logic               w_in;
      logic               w_out;
      logic               w_ld_main;
      logic               w_ld_skid;
      logic               w_main_from_skid;

      assign w_in  = w_val[k] & r_rdy;
      assign w_out = (r_state != ST_EMPTY) & w_rdy[k+1];

      always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_ld_skid        = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
          ST_EMPTY: begin
            if (w_in) begin
              w_state_nxt = ST_BUSY;
              w_ld_main   = 1'b1;
            end
          end
          ST_BUSY: begin
            if (w_in && w_out) begin
              w_ld_main   = 1'b1;
            end else if (w_in) begin
              w_state_nxt = ST_FULL;
              w_ld_skid   = 1'b1;
            end else if (w_out) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (w_out) begin
              w_state_nxt      = ST_BUSY;
              w_ld_main        = 1'b1;
              w_main_from_skid = 1'b1;
            end
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_state <= ST_EMPTY;
          r_rdy   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_rdy   <= (w_state_nxt != ST_FULL);
        end
      end

      // Payload registers carry no reset; the state flags qualify them.
      always_ff @(posedge clk) begin
        if (w_ld_main) r_main <= w_main_from_skid ? r_skid : w_data[k];
        if (w_ld_skid) r_skid <= w_data[k];
      end

      assign w_data[k+1] = r_main;
      assign w_val[k+1]  = (r_state != ST_EMPTY);
      assign w_rdy[k]    = r_rdy;
`ifdef AXI_CH_RETIME_SKID_OCC_EN
      assign w_cnt_nxt[k] = (w_state_nxt == ST_FULL) ? 2'd2 :
                            (w_state_nxt == ST_BUSY) ? 2'd1 : 2'd0;
`endif
    end

`ifdef AXI_CH_RETIME_SKID_OCC_EN
    always_comb begin
      w_occ_nxt = '0;
      for (int k = 0; k < P_STAGES; k++) w_occ_nxt = w_occ_nxt + LP_OCC_W'(w_cnt_nxt[k]);
    end

    always_ff @(posedge clk) begin
      if (!reset) r_occ <= '0;
      else        r_occ <= w_occ_nxt;
    end

    assign o_occ = r_occ;
`endif
  end

endmodule
